// File: rtl/tile_lane_scroller_if.sv
// tile_lane_scroller_if: lane request/query inputs and event/pixel outputs of one tile lane.
interface tile_lane_scroller_if #(
    parameter int MAX_TILES = 4
);
    localparam int CW = $clog2(MAX_TILES + 1);
    logic          frame_tick;
    logic          spawn;
    logic          hit;
    logic [7:0]    VGA_X;
    logic [6:0]    VGA_Y;
    logic [2:0]    tile_color;
    logic          tile_plot;
    logic          hit_ok;
    logic          hit_miss;
    logic          tile_escaped;
    logic          spawn_drop;
    logic [CW-1:0] count;
    logic          full;
    modport master (
        output frame_tick, spawn, hit, VGA_X, VGA_Y,
        input  tile_color, tile_plot, hit_ok, hit_miss, tile_escaped, spawn_drop, count, full
    );
    modport slave (
        input  frame_tick, spawn, hit, VGA_X, VGA_Y,
        output tile_color, tile_plot, hit_ok, hit_miss, tile_escaped, spawn_drop, count, full
    );
endinterface

// File: rtl/tile_lane_scroller.sv
// tile_lane_scroller: circular buffer of falling tiles in one lane; scrolls, spawns, scores hits
// and answers registered per-pixel tile queries.
module tile_lane_scroller #(
    parameter int         X_START       = 0,
    parameter int         TILE_WIDTH    = 39,
    parameter int         TILE_HEIGHT   = 30,
    parameter int         MAX_TILES     = 4,
    parameter int         SPEED         = 1,
    parameter int         SCREEN_HEIGHT = 120,
    parameter int         HIT_ZONE      = 90,
    parameter logic [2:0] TILE_COLOR    = 3'b000
) (
    input logic CLOCK_50,
    input logic reset,
    tile_lane_scroller_if.slave bus
);
    localparam int              CW     = $clog2(MAX_TILES + 1);
    localparam int              IW     = $clog2(MAX_TILES);
    localparam logic [8:0]      ESC_B  = 9'(SCREEN_HEIGHT + TILE_HEIGHT);
    localparam logic [8:0]      TH9    = 9'(TILE_HEIGHT);
    localparam logic [8:0]      SP9    = 9'(SPEED);
    localparam logic [8:0]      XLO    = 9'(X_START);
    localparam logic [8:0]      XHI    = 9'(X_START + TILE_WIDTH);
    localparam logic [7:0]      TH8    = 8'(TILE_HEIGHT);
    localparam logic [7:0]      HZ8    = 8'(HIT_ZONE);
    localparam logic [7:0]      SP8    = 8'(SPEED);
    localparam logic [IW-1:0]   LAST   = IW'(MAX_TILES - 1);
    localparam logic [CW-1:0]   FULL_C = CW'(MAX_TILES);

    logic [7:0]           r_b [MAX_TILES];
    logic [MAX_TILES-1:0] r_valid;
    logic [IW-1:0]        r_head, r_tail;
    logic [CW-1:0]        r_count;
    logic                 r_plot, r_hit_ok, r_hit_miss, r_escaped, r_drop, r_full;
    logic [2:0]           r_color;

    logic [MAX_TILES-1:0] w_match;
    logic [IW-1:0]        w_head1, w_head2, w_tail1, w_tail_prev, w_esc_idx, w_head_nxt;
    logic [CW-1:0]        w_count_nxt;
    logic                 w_hit_ok, w_esc, w_push, w_in_x, w_plot;

    assign w_head1     = (r_head == LAST) ? '0 : r_head + 1'b1;
    assign w_head2     = (w_head1 == LAST) ? '0 : w_head1 + 1'b1;
    assign w_tail1     = (r_tail == LAST) ? '0 : r_tail + 1'b1;
    assign w_tail_prev = (r_tail == '0) ? LAST : r_tail - 1'b1;

    assign w_hit_ok  = bus.hit && r_count != '0 && r_b[r_head] >= HZ8;
    // When the hit consumes the head, the escape candidate is the tile behind it.
    assign w_esc_idx = w_hit_ok ? w_head1 : r_head;
    assign w_esc     = bus.frame_tick && (w_hit_ok ? r_count > CW'(1) : r_count != '0)
                       && ({1'b0, r_b[w_esc_idx]} + SP9 >= ESC_B);
    assign w_push    = bus.spawn && r_count != FULL_C && !(r_count != '0 && r_b[w_tail_prev] < TH8);

    assign w_count_nxt = r_count + CW'(w_push) - CW'(w_hit_ok) - CW'(w_esc);
    assign w_head_nxt  = (w_hit_ok && w_esc) ? w_head2 : (w_hit_ok || w_esc) ? w_head1 : r_head;

    assign w_in_x = {1'b0, bus.VGA_X} >= XLO && {1'b0, bus.VGA_X} < XHI;
    for (genvar g = 0; g < MAX_TILES; g++) begin : g_match
        assign w_match[g] = r_valid[g] && {2'b0, bus.VGA_Y} < {1'b0, r_b[g]}
                            && {2'b0, bus.VGA_Y} + TH9 >= {1'b0, r_b[g]};
    end
    assign w_plot = w_in_x && |w_match;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_b        <= '{default: '0};
            r_valid    <= '0;
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= '0;
            r_plot     <= 1'b0;
            r_color    <= 3'b000;
            r_hit_ok   <= 1'b0;
            r_hit_miss <= 1'b0;
            r_escaped  <= 1'b0;
            r_drop     <= 1'b0;
            r_full     <= 1'b0;
        end else begin
            for (int i = 0; i < MAX_TILES; i++)
                if (bus.frame_tick && r_valid[i] && !(w_hit_ok && IW'(i) == r_head))
                    r_b[i] <= r_b[i] + SP8;
            if (w_hit_ok)
                r_valid[r_head] <= 1'b0;
            if (w_esc)
                r_valid[w_esc_idx] <= 1'b0;
            if (w_push) begin
                r_b[r_tail]     <= '0;
                r_valid[r_tail] <= 1'b1;
                r_tail          <= w_tail1;
            end
            r_head     <= w_head_nxt;
            r_count    <= w_count_nxt;
            r_full     <= w_count_nxt == FULL_C;
            r_plot     <= w_plot;
            r_color    <= w_plot ? TILE_COLOR : 3'b000;
            r_hit_ok   <= w_hit_ok;
            r_hit_miss <= bus.hit && !w_hit_ok;
            r_escaped  <= w_esc;
            r_drop     <= bus.spawn && !w_push;
        end
    end

    assign bus.tile_plot    = r_plot;
    assign bus.tile_color   = r_color;
    assign bus.hit_ok       = r_hit_ok;
    assign bus.hit_miss     = r_hit_miss;
    assign bus.tile_escaped = r_escaped;
    assign bus.spawn_drop   = r_drop;
    assign bus.count        = r_count;
    assign bus.full         = r_full;
endmodule
